// File: rtl/locker_pkg.sv
// Shared types and constants for the locker session controller.
// Holds the FSM state encoding, keypad codes, servo angles and timer width.
package locker_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam int unsigned TMR_W = 28;

  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] KEY_IDLE_DEF   = 4'hF;
  localparam logic [3:0] RELOCK_KEY_DEF = 4'hB;

  localparam logic [7:0] ANGLE_OPEN_DEF   = 8'd90;
  localparam logic [7:0] ANGLE_CLOSED_DEF = 8'd0;

endpackage

// File: rtl/locker_timer.sv
// Loadable down-counter shared by the door-open hold and the lockout period.
// Counts down while run is high and parks at zero; load takes priority.
module locker_timer
  import locker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_value,
  input  logic             run,
  output logic [TMR_W-1:0] value,
  output logic             zero
);

  logic [TMR_W-1:0] count_r;
  logic [TMR_W-1:0] count_nxt_s;

  // Next count: load, decrement, or hold at zero / when idle.
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_value;
    end else if (run && (count_r != TMR_ZERO)) begin
      count_nxt_s = count_r - TMR_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= TMR_ZERO;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign value = count_r;
  assign zero  = (count_r == TMR_ZERO);

endmodule

// File: rtl/locker_session_ctrl.sv
// Locker session FSM: servo open/close sequencing, consecutive-failure
// counting and alarm-plus-lockout with keypad masking. All outputs registered.
module locker_session_ctrl
  import locker_pkg::*;
#(
  parameter logic [TMR_W-1:0] OPEN_CYCLES    = 28'd60000000,
  parameter logic [TMR_W-1:0] LOCKOUT_CYCLES = 28'd240000000,
  parameter logic [TMR_W-1:0] ALARM_CYCLES   = 28'd36000000,
  parameter logic [3:0]       MAX_FAIL       = 4'd3,
  parameter logic [7:0]       ANGLE_OPEN     = ANGLE_OPEN_DEF,
  parameter logic [7:0]       ANGLE_CLOSED   = ANGLE_CLOSED_DEF,
  parameter logic [3:0]       KEY_IDLE       = KEY_IDLE_DEF,
  parameter logic [3:0]       RELOCK_KEY     = RELOCK_KEY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       pw_true,
  input  logic       pw_false,
  input  logic       timeout_flag,
  output logic [3:0] key_out,
  output logic [7:0] angle,
  output logic       alarm,
  output logic       locked_out,
  output logic [3:0] fail_cnt,
  output logic [1:0] state
);

  // Alarm is on while the timer is at or above this; zero means the whole lockout.
  localparam logic [TMR_W-1:0] ALARM_THRESH =
    (ALARM_CYCLES >= LOCKOUT_CYCLES) ? TMR_ZERO : (LOCKOUT_CYCLES - ALARM_CYCLES);

  state_t           state_r, state_nxt_s;
  logic [3:0]       fail_cnt_r, fail_nxt_s;
  logic [3:0]       prev_key_r;
  logic [3:0]       key_out_r, key_out_nxt_s;
  logic [7:0]       angle_r, angle_nxt_s;
  logic             alarm_r, alarm_nxt_s;
  logic             locked_out_r, locked_out_nxt_s;
  logic             load_s, run_s, relock_s;
  logic [TMR_W-1:0] load_val_s, tmr_value_s, tmr_after_s;
  logic             tmr_zero_s;
  logic [4:0]       fail_inc_s;

  locker_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_value (load_val_s),
    .run        (run_s),
    .value      (tmr_value_s),
    .zero       (tmr_zero_s)
  );

  // Next-state, failure count, timer control and next registered outputs.
  always_comb begin
    state_nxt_s = state_r;
    fail_nxt_s  = fail_cnt_r;
    load_s      = 1'b0;
    load_val_s  = TMR_ZERO;
    run_s       = (state_r == ST_OPEN) || (state_r == ST_LOCKOUT);
    relock_s    = (key_in == RELOCK_KEY) && (prev_key_r == KEY_IDLE);
    fail_inc_s  = {1'b0, fail_cnt_r} + 5'd1;

    case (state_r)
      ST_LOCKED: begin
        if (pw_false) begin
          if (fail_inc_s >= {1'b0, MAX_FAIL}) begin
            state_nxt_s = ST_LOCKOUT;
            load_s      = 1'b1;
            load_val_s  = LOCKOUT_CYCLES - TMR_ONE;
            fail_nxt_s  = MAX_FAIL;
          end else begin
            fail_nxt_s  = fail_inc_s[3:0];
          end
        end else if (pw_true) begin
          state_nxt_s = ST_OPEN;
          load_s      = 1'b1;
          load_val_s  = OPEN_CYCLES - TMR_ONE;
          fail_nxt_s  = 4'd0;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (relock_s || tmr_zero_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_LOCKED;
          fail_nxt_s  = 4'd0;
        end else begin
          state_nxt_s = ST_LOCKOUT;
        end
      end
      default: begin
        state_nxt_s = ST_LOCKED;
      end
    endcase

    // Timer value that will be in place after this edge.
    if (load_s) begin
      tmr_after_s = load_val_s;
    end else if (run_s && !tmr_zero_s) begin
      tmr_after_s = tmr_value_s - TMR_ONE;
    end else begin
      tmr_after_s = tmr_value_s;
    end

    locked_out_nxt_s = (state_nxt_s == ST_LOCKOUT);
    alarm_nxt_s      = locked_out_nxt_s && (tmr_after_s >= ALARM_THRESH);
    angle_nxt_s      = (state_nxt_s == ST_OPEN) ? ANGLE_OPEN : ANGLE_CLOSED;
    key_out_nxt_s    = locked_out_nxt_s ? KEY_IDLE : key_in;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LOCKED;
      fail_cnt_r   <= 4'd0;
      prev_key_r   <= KEY_IDLE;
      key_out_r    <= KEY_IDLE;
      angle_r      <= ANGLE_CLOSED;
      alarm_r      <= 1'b0;
      locked_out_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fail_cnt_r   <= fail_nxt_s;
      prev_key_r   <= key_in;
      key_out_r    <= key_out_nxt_s;
      angle_r      <= angle_nxt_s;
      alarm_r      <= alarm_nxt_s;
      locked_out_r <= locked_out_nxt_s;
    end
  end

  assign state      = state_r;
  assign fail_cnt   = fail_cnt_r;
  assign key_out    = key_out_r;
  assign angle      = angle_r;
  assign alarm      = alarm_r;
  assign locked_out = locked_out_r;

endmodule
